// File: rtl/adc_serial_tx_if.sv
// adc_serial_tx_if: parallel sample handshake between a producer and adc_serial_tx.
//
// Signals:
//   sample_data   parallel sample, WIDTH bits
//   sample_valid  producer has a sample on sample_data
//   sample_ready  serializer can accept a sample this cycle
//
// Modports:
//   master  producer side (drives data/valid, observes ready)
//   slave   serializer side (observes data/valid, drives ready)

interface adc_serial_tx_if #(
    parameter int unsigned WIDTH = 12
) ();

    logic [WIDTH-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/adc_serial_tx.sv
// adc_serial_tx: ADC-side model of the digitizer's single-lane serial data link.
//
// Takes parallel samples through a valid/ready handshake and shifts them out one
// bit per adc_fast_clk edge, MSB first, with adc_frame high for the first half of
// each word. If no sample is available at a word boundary a fill word is sent and
// underrun_cnt (saturating) is incremented.
//
// Ports:
//   adc_fast_clk  bit clock, one serial bit per rising edge
//   reset         asynchronous, active-high
//   enable        level; start or continue streaming (sampled at word boundaries)
//   sample_if     slave modport: sample_data / sample_valid in, sample_ready out
//   adc_data_p    serial data, MSB first (0 while idle)
//   adc_frame     high for the first WIDTH/2 bits of each word
//   word_start    one-cycle pulse while the MSB of a word is on adc_data_p
//   underrun_cnt  saturating count of fill words sent
//
// Configuration macro:
//   ADC_TX_TEST_PATTERN_EN  defined: fill word is a WIDTH-bit ramp counter that
//                           advances after each fill load.
//                           undefined: fill word is constant zero.

module adc_serial_tx #(
    parameter int unsigned WIDTH = 12
) (
    input  logic                  adc_fast_clk,
    input  logic                  reset,
    input  logic                  enable,
    adc_serial_tx_if.slave        sample_if,
    output logic                  adc_data_p,
    output logic                  adc_frame,
    output logic                  word_start,
    output logic [7:0]            underrun_cnt
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(WIDTH / 2);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("adc_serial_tx: WIDTH must be even and at least 4");
    end

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       underrun_q, underrun_d;

    logic             last_bit;
    logic             load;
    logic             accept;
    logic             fill_used;
    logic [WIDTH-1:0] fill_word;

    // Handshake: ready only reflects the holding register, never sample_valid.
    assign sample_if.sample_ready = ~hold_full_q;
    assign accept    = sample_if.sample_valid & ~hold_full_q;

    assign last_bit  = (state_q == StRun) && (bit_cnt_q == LastBit);
    // Word boundary where a new word is loaded; with enable low at the last bit
    // the current word finishes and we drop to idle instead.
    assign load      = enable && ((state_q == StIdle) || last_bit);
    assign fill_used = load && !hold_full_q && !sample_if.sample_valid;

`ifdef ADC_TX_TEST_PATTERN_EN
    logic [WIDTH-1:0] ramp_q, ramp_d;

    always_comb begin
        ramp_d = ramp_q;
        if (fill_used) begin
            ramp_d = ramp_q + WIDTH'(1);
        end
    end

    always_ff @(posedge adc_fast_clk or posedge reset) begin
        if (reset) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end

    assign fill_word = ramp_q;
`else
    assign fill_word = '0;
`endif

    // FSM: state register
    always_ff @(posedge adc_fast_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable)              state_d = StRun;
            StRun:  if (last_bit && !enable) state_d = StIdle;
        endcase
    end

    // FSM: outputs, decoded from registers only
    always_comb begin
        adc_data_p = 1'b0;
        adc_frame  = 1'b0;
        word_start = 1'b0;
        if (state_q == StRun) begin
            adc_data_p = shreg_q[WIDTH-1];
            adc_frame  = bit_cnt_q < HalfBit;
            word_start = bit_cnt_q == '0;
        end
    end

    // Datapath next state
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;

        if (load) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (sample_if.sample_valid) begin
                // Bypass: accepted straight into the shifter, hold stays empty.
                shreg_d = sample_if.sample_data;
            end else begin
                shreg_d = fill_word;
                if (underrun_q != 8'hFF) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
        end else begin
            if (state_q == StRun) begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                // Stop edge wraps the counter so idle decodes cleanly.
                bit_cnt_d = last_bit ? '0 : bit_cnt_q + CntW'(1);
            end
            if (accept) begin
                hold_d      = sample_if.sample_data;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge adc_fast_clk or posedge reset) begin
        if (reset) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= '0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
        end
    end

    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_adc_serial_tx.sv
// tb_adc_serial_tx: directed self-checking bench for adc_serial_tx (WIDTH = 12).
// A negedge monitor reassembles serial words (data, frame pattern, start cycle)
// into queues; the main sequence drives the handshake and checks against
// hand-computed values.

module tb_adc_serial_tx;

    logic       adc_fast_clk;
    logic       reset;
    logic       enable;
    logic       adc_data_p;
    logic       adc_frame;
    logic       word_start;
    logic [7:0] underrun_cnt;

    adc_serial_tx_if #(.WIDTH(12)) sif ();

    adc_serial_tx #(.WIDTH(12)) dut (
        .adc_fast_clk (adc_fast_clk),
        .reset        (reset),
        .enable       (enable),
        .sample_if    (sif.slave),
        .adc_data_p   (adc_data_p),
        .adc_frame    (adc_frame),
        .word_start   (word_start),
        .underrun_cnt (underrun_cnt)
    );

    initial adc_fast_clk = 1'b0;
    always #5 adc_fast_clk = ~adc_fast_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge adc_fast_clk) cyc <= cyc + 1;

    // Word monitor
    logic [11:0] q_word [$];
    logic [11:0] q_frame [$];
    int          q_start [$];
    logic [11:0] mon_word  = '0;
    logic [11:0] mon_frame = '0;
    int          mon_cnt   = 0;
    int          mon_start = 0;

    always @(negedge adc_fast_clk) begin
        if (reset) begin
            mon_cnt <= 0;
        end else if (word_start) begin
            mon_word  <= {11'b0, adc_data_p};
            mon_frame <= {11'b0, adc_frame};
            mon_cnt   <= 1;
            mon_start <= cyc;
        end else if (mon_cnt != 0) begin
            if (mon_cnt == 11) begin
                q_word.push_back({mon_word[10:0], adc_data_p});
                q_frame.push_back({mon_frame[10:0], adc_frame});
                q_start.push_back(mon_start);
                mon_cnt <= 0;
            end else begin
                mon_word  <= {mon_word[10:0], adc_data_p};
                mon_frame <= {mon_frame[10:0], adc_frame};
                mon_cnt   <= mon_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge adc_fast_clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!sif.sample_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    // Offer one sample; it must land in hold (ready drops afterwards).
    task automatic send(input logic [11:0] d, input string tag);
        sif.sample_data  = d;
        sif.sample_valid = 1'b1;
        wait_ready(tag);
        tick();
        sif.sample_valid = 1'b0;
        check_eq({tag, "_ready_drop"}, 32'(sif.sample_ready), 0);
    endtask

    task automatic clear_q();
        q_word.delete();
        q_frame.delete();
        q_start.delete();
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq(tag, 32'({word_start, adc_frame, adc_data_p}), 0);
        end
    endtask

    logic [11:0] exp2 [4];
    logic [11:0] fill [3];
    int          c;

    initial begin
        exp2 = '{12'hA5C, 12'h001, 12'hFFF, 12'h800};
`ifdef ADC_TX_TEST_PATTERN_EN
        fill = '{12'h000, 12'h001, 12'h002};
`else
        fill = '{12'h000, 12'h000, 12'h000};
`endif
        reset            = 1'b1;
        enable           = 1'b0;
        sif.sample_data  = '0;
        sif.sample_valid = 1'b0;
        repeat (3) tick();

        check_eq("rst_data_p", 32'(adc_data_p), 0);
        check_eq("rst_frame", 32'(adc_frame), 0);
        check_eq("rst_word_start", 32'(word_start), 0);
        check_eq("rst_ready", 32'(sif.sample_ready), 1);
        check_eq("rst_underrun", 32'(underrun_cnt), 0);
        reset = 1'b0;
        tick();

        // A5C then back-to-back 001, FFF, 800
        clear_q();
        send(12'hA5C, "a5c");
        enable = 1'b1;
        c = cyc;
        tick();
        send(12'h001, "s001");
        send(12'hFFF, "sfff");
        send(12'h800, "s800");
        wait_ready("s800_load");
        enable = 1'b0;
        repeat (14) tick();
        check_eq("b2b_count", q_word.size(), 4);
        for (int i = 0; i < 4 && i < q_word.size(); i++) begin
            check_eq($sformatf("b2b_word%0d", i), 32'(q_word[i]), 32'(exp2[i]));
            check_eq($sformatf("b2b_frame%0d", i), 32'(q_frame[i]), 32'h0000_0FC0);
            check_eq($sformatf("b2b_start%0d", i), q_start[i], c + 1 + 12 * i);
        end
        check_eq("b2b_underrun", 32'(underrun_cnt), 0);
        check_idle("b2b_idle", 5);

        // Three underrun words
        clear_q();
        enable = 1'b1;
        repeat (25) tick();
        enable = 1'b0;
        repeat (14) tick();
        check_eq("fill_count", q_word.size(), 3);
        for (int i = 0; i < 3 && i < q_word.size(); i++) begin
            check_eq($sformatf("fill_word%0d", i), 32'(q_word[i]), 32'(fill[i]));
        end
        check_eq("fill_underrun", 32'(underrun_cnt), 3);

        // Enable dropped at bit 4: word completes, then silence
        clear_q();
        send(12'h3C3, "s3c3");
        enable = 1'b1;
        tick();
        repeat (4) tick();
        enable = 1'b0;
        repeat (8) tick();
        check_eq("stop_count", q_word.size(), 1);
        if (q_word.size() > 0) check_eq("stop_word", 32'(q_word[0]), 32'h3C3);
        check_idle("stop_idle", 6);
        check_eq("stop_underrun", 32'(underrun_cnt), 3);
        clear_q();
        send(12'h5A6, "s5a6");
        enable = 1'b1;
        c = cyc;
        tick();
        wait_ready("s5a6_load");
        enable = 1'b0;
        repeat (14) tick();
        check_eq("resume_count", q_word.size(), 1);
        if (q_word.size() > 0) begin
            check_eq("resume_word", 32'(q_word[0]), 32'h5A6);
            check_eq("resume_start", q_start[0], c + 1);
        end

        // Reset at bit 7 of word 0F0 (bit 7 is a 1)
        clear_q();
        send(12'h0F0, "s0f0");
        enable = 1'b1;
        tick();
        repeat (7) tick();
        check_eq("pre_rst_data_p", 32'(adc_data_p), 1);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check_eq("mid_rst_data_p", 32'(adc_data_p), 0);
        check_eq("mid_rst_frame", 32'(adc_frame), 0);
        check_eq("mid_rst_underrun", 32'(underrun_cnt), 0);
        check_eq("mid_rst_ready", 32'(sif.sample_ready), 1);
        repeat (2) tick();
        reset = 1'b0;
        check_eq("post_rst_ready", 32'(sif.sample_ready), 1);
        tick();
        check_eq("post_rst_partial", q_word.size(), 0);
        send(12'h9C3, "s9c3");
        enable = 1'b1;
        c = cyc;
        tick();
        wait_ready("s9c3_load");
        enable = 1'b0;
        repeat (14) tick();
        check_eq("post_rst_count", q_word.size(), 1);
        if (q_word.size() > 0) begin
            check_eq("post_rst_word", 32'(q_word[0]), 32'h9C3);
            check_eq("post_rst_start", q_start[0], c + 1);
        end

        // 300 consecutive underruns: saturate at 255
        clear_q();
        enable = 1'b1;
        repeat (1 + 12 * 199) tick();
        check_eq("sat_200", 32'(underrun_cnt), 200);
        repeat (12 * 100) tick();
        enable = 1'b0;
        check_eq("sat_300", 32'(underrun_cnt), 255);
        repeat (14) tick();
        check_eq("sat_hold", 32'(underrun_cnt), 255);
        check_eq("sat_count", q_word.size(), 300);
`ifdef ADC_TX_TEST_PATTERN_EN
        if (q_word.size() == 300) check_eq("sat_last_fill", 32'(q_word[299]), 32'h12B);
`else
        if (q_word.size() == 300) check_eq("sat_last_fill", 32'(q_word[299]), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
